gowin_ddr: RTL and testbench

7:1 output gearbox for the LVDS panel transmitter. Each frame, it captures a 49-bit parallel word holding 7 lanes × 7 bit-slots. It then presents one 7-bit lane vector per clock, so each lane output carries one bit per cycle toward the I/O serializers / LVDS pads. A single fast clock drives everything. The block itself generates the word-rate load strobe, and upstream logic uses that strobe to present `din`.

---
 rtl/gowin_ddr.sv | 50 +++++
 tb/tb_gowin_ddr.sv | 128 ++++++++++++
 2 files changed

// File: rtl/gowin_ddr.sv
// gowin_ddr: 7:1 output gearbox for the LVDS panel transmitter.
// It captures one 49-bit frame (7 time slots x 7 lanes) once every
// seven bit-rate clocks. It then presents one 7-bit lane vector per
// clock, sending slot 0 first. The block generates its own word-rate
// load strobe, and upstream presents the next frame against that strobe.
module gowin_ddr (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic [48:0] din,
    output logic        o_load,
    output logic [6:0]  q
);

    localparam logic [2:0] LAST_SLOT = 3'd6;

    // Position within the current frame. Slot 6 is the cycle whose
    // closing edge captures the next frame.
    logic [2:0]  slot;

    // Slots 1..6 of the frame currently being sent. Slot 1 sits in the
    // low bits, and each edge moves the next slot down.
    logic [41:0] hold;

    // Decode the load strobe from registered state so that it is clean
    // for upstream logic.
    assign o_load = (slot == LAST_SLOT);

    // Slot counter, capture register and output register.
    // NOTE: sequential state uses non-blocking assignments, so every
    // right-hand side below sees the pre-edge values of slot and hold.
    // NOTE: all state here is plain flops, and all of it is reset. As a
    // result, a mid-frame reset discards the partial frame and q drops
    // to zero at once.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            slot <= 3'd0;
            hold <= '0;
            q    <= '0;
        end else if (slot == LAST_SLOT) begin
            slot <= 3'd0;
            q    <= din[6:0];
            hold <= din[48:7];
        end else begin
            slot <= slot + 3'd1;
            q    <= hold[6:0];
            hold <= hold >> 7;
        end
    end

endmodule

// File: tb/tb_gowin_ddr.sv
// Directed testbench for gowin_ddr.
// Inputs are driven and outputs are sampled on the falling clock edge.
// The DUT updates on the rising edge.
module tb_gowin_ddr;

    logic        i_clk;
    logic        i_resetn;
    logic [48:0] din;
    logic        o_load;
    logic [6:0]  q;

    int checks = 0;
    int errors = 0;

    gowin_ddr dut (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .din      (din),
        .o_load   (o_load),
        .q        (q)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Safety net: stop the run if it ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rand_din();
        logic [63:0] r;
        r   = {$urandom, $urandom};
        din = r[48:0];
    endtask

    // Six edges after a reset release: q is 0 throughout, and o_load
    // rises only after the sixth edge. At that point the next frame is
    // presented.
    task automatic startup(input logic [48:0] first);
        for (int k = 1; k <= 6; k++) begin
            @(negedge i_clk);
            chk($sformatf("startup_q_e%0d", k), q, 7'h00);
            chk($sformatf("startup_load_e%0d", k), {6'b0, o_load}, {6'b0, k == 6});
            if (k == 6) din = first;
            else        rand_din();
        end
    endtask

    // One frame after a load edge. Slot t of the loaded word is expected
    // on q, and o_load must be high only in slot 6. The next frame is
    // driven during that slot. When dc is set, din carries noise on the
    // other cycles.
    task automatic frame(input string name, input logic [48:0] loaded,
                         input logic [48:0] next, input bit dc);
        for (int t = 0; t < 7; t++) begin
            @(negedge i_clk);
            chk($sformatf("%s_q_s%0d", name, t), q, loaded[7*t +: 7]);
            chk($sformatf("%s_load_s%0d", name, t), {6'b0, o_load}, {6'b0, t == 6});
            if (t == 6)  din = next;
            else if (dc) rand_din();
        end
    endtask

    localparam logic [48:0] W_ORDER = {7'h7F, 7'h3F, 7'h1F, 7'h0F, 7'h07, 7'h03, 7'h01};
    localparam logic [48:0] W_ONES  = {49{1'b1}};
    localparam logic [48:0] W_ZERO  = '0;
    // Lane 6 pattern 1100011 on din[48]..din[6]; all other lanes are 0.
    localparam logic [48:0] W_CLK   = {7'h40, 7'h40, 7'h00, 7'h00, 7'h00, 7'h40, 7'h40};
    localparam logic [48:0] W_R1    = 49'h1_2345_6789_ABCD;
    localparam logic [48:0] W_R2    = 49'h0_F0E1_D2C3_B4A5;

    initial begin
        i_resetn = 1'b0;
        din      = '0;

        // Hold reset for five cycles.
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            chk("rst_q", q, 7'h00);
            chk("rst_load", {6'b0, o_load}, 7'h00);
        end
        i_resetn = 1'b1;

        startup(W_ORDER);
        frame("order", W_ORDER, W_ONES, 1'b0);
        frame("ones",  W_ONES,  W_ZERO, 1'b0);
        frame("zeros", W_ZERO,  W_CLK,  1'b0);
        frame("clk",   W_CLK,   W_R1,   1'b1);
        frame("dc1",   W_R1,    W_R2,   1'b1);

        // Send W_R2 partway. Then assert reset between edges while the
        // DUT is in slot 3.
        for (int t = 0; t < 4; t++) begin
            @(negedge i_clk);
            chk($sformatf("mid_q_s%0d", t), q, W_R2[7*t +: 7]);
            rand_din();
        end
        #2 i_resetn = 1'b0;
        #1;
        chk("mid_async_q", q, 7'h00);
        chk("mid_async_load", {6'b0, o_load}, 7'h00);
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            chk("mid_rst_q", q, 7'h00);
            chk("mid_rst_load", {6'b0, o_load}, 7'h00);
        end
        i_resetn = 1'b1;

        startup(W_CLK);
        frame("restart", W_CLK, W_ORDER, 1'b1);
        frame("after", W_ORDER, W_ZERO, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
